// File: rtl/mix_matrix_core.sv
// mix_matrix_core: NUM_OUT x NUM_IN gain matrix computed once per sample with a
// single time-multiplexed pipelined MAC and a host-writable coefficient RAM.
// Optional build macro MIX_SATURATE_EN: clamp each row result to the WIDTH-bit
// signed range instead of keeping the low WIDTH bits (wrap-around).
module mix_matrix_core #(
  parameter int NUM_IN     = 8,
  parameter int NUM_OUT    = 8,
  parameter int WIDTH      = 36,
  parameter int COEF_WIDTH = 18,
  parameter int COEF_FRAC  = 16,
  localparam int DEPTH     = NUM_IN * NUM_OUT,
  localparam int ADDR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic signed [WIDTH-1:0]      inputs [NUM_IN],
  output logic signed [WIDTH-1:0]      outputs [NUM_OUT],
  input  logic                         coef_we,
  input  logic [ADDR_W-1:0]            coef_addr,
  input  logic signed [COEF_WIDTH-1:0] coef_wdata,
  output logic                         busy,
  output logic                         done
);

  localparam int PW    = WIDTH + COEF_WIDTH;
  localparam int AW    = PW + $clog2(NUM_IN) + 1;
  localparam int COL_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;
  localparam int ROW_W = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;
  localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [COL_W-1:0]  LAST_COL  = COL_W'(NUM_IN - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, COMMIT} state_t;

  state_t state_reg, state_next;
  logic                         drain_reg;
  logic [ADDR_W-1:0]            cnt_reg;
  logic [COL_W-1:0]             col_reg;
  logic [ROW_W-1:0]             row_reg;
  logic signed [WIDTH-1:0]      shadow_reg [NUM_IN];
  logic signed [COEF_WIDTH-1:0] coef_mem [DEPTH];
  logic signed [COEF_WIDTH-1:0] rd_data_reg;
  logic                         v1_reg, first1_reg, last1_reg;
  logic [COL_W-1:0]             col1_reg;
  logic [ROW_W-1:0]             row1_reg;
  logic                         v2_reg, first2_reg, last2_reg;
  logic [ROW_W-1:0]             row2_reg;
  logic signed [PW-1:0]         mul_a, mul_b, prod_reg;
  logic signed [AW-1:0]         prod_ext, acc_reg, sum_next;
  logic signed [WIDTH-1:0]      row_result;
  logic                         done_reg;

  assign busy = (state_reg != IDLE);
  assign done = done_reg;

  // state register
  always_ff @(posedge clk) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  // next-state logic: RUN issues one read per cycle, DRAIN flushes two pipe stages
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (cnt_reg == LAST_ADDR) state_next = DRAIN;
      DRAIN:   if (drain_reg) state_next = COMMIT;
      COMMIT:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // read sequencing counters and input capture on accepted start
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_reg   <= '0;
      col_reg   <= '0;
      row_reg   <= '0;
      drain_reg <= 1'b0;
    end else begin
      drain_reg <= (state_reg == DRAIN) && !drain_reg;
      if (state_reg == IDLE && start) begin
        cnt_reg    <= '0;
        col_reg    <= '0;
        row_reg    <= '0;
        shadow_reg <= inputs;
      end else if (state_reg == RUN) begin
        cnt_reg <= cnt_reg + 1'b1;
        if (col_reg == LAST_COL) begin
          col_reg <= '0;
          row_reg <= row_reg + 1'b1;
        end else begin
          col_reg <= col_reg + 1'b1;
        end
      end
    end
  end

  // coefficient RAM: host write port, registered read returns the pre-write value
  always_ff @(posedge clk) begin
    if (coef_we && ({1'b0, coef_addr} < DEPTH_EXT)) coef_mem[coef_addr] <= coef_wdata;
    rd_data_reg <= coef_mem[cnt_reg];
  end

  assign mul_a    = PW'(shadow_reg[col1_reg]);
  assign mul_b    = PW'(rd_data_reg);
  assign prod_ext = AW'(prod_reg);

  // MAC pipeline: tags travel alongside the RAM data and the product
  always_ff @(posedge clk) begin
    if (reset) begin
      v1_reg <= 1'b0;
      v2_reg <= 1'b0;
    end else begin
      v1_reg <= (state_reg == RUN);
      v2_reg <= v1_reg;
    end
    col1_reg   <= col_reg;
    row1_reg   <= row_reg;
    first1_reg <= (col_reg == '0);
    last1_reg  <= (col_reg == LAST_COL);
    prod_reg   <= mul_a * mul_b;
    row2_reg   <= row1_reg;
    first2_reg <= first1_reg;
    last2_reg  <= last1_reg;
  end

  // running sum; the first term of a row replaces the old total
  always_comb begin
    sum_next = first2_reg ? prod_ext : (acc_reg + prod_ext);
  end

  // accumulator register
  always_ff @(posedge clk) begin
    if (reset)       acc_reg <= '0;
    else if (v2_reg) acc_reg <= sum_next;
  end

`ifdef MIX_SATURATE_EN
  localparam logic signed [AW-1:0] SAT_MAX = {{(AW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [AW-1:0] SAT_MIN = {{(AW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};
  logic signed [AW-1:0] shifted;

  // floor-scale then clamp to the signed output range
  always_comb begin
    shifted    = sum_next >>> COEF_FRAC;
    row_result = WIDTH'(shifted);
    if (shifted > SAT_MAX)      row_result = WIDTH'(SAT_MAX);
    else if (shifted < SAT_MIN) row_result = WIDTH'(SAT_MIN);
  end
`else
  assign row_result = WIDTH'(sum_next >>> COEF_FRAC);
`endif

  // done pulse coincides with the output update
  always_ff @(posedge clk) begin
    if (reset) done_reg <= 1'b0;
    else       done_reg <= (state_reg == COMMIT);
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_OUT; gi++) begin : g_ch
      logic signed [WIDTH-1:0] stage_reg;
      logic signed [WIDTH-1:0] out_reg;

      // staging captures the finished row; outputs copy the whole bank at commit
      always_ff @(posedge clk) begin
        if (reset) begin
          stage_reg <= '0;
          out_reg   <= '0;
        end else begin
          if (v2_reg && last2_reg && row2_reg == ROW_W'(gi)) stage_reg <= row_result;
          if (state_reg == COMMIT) out_reg <= stage_reg;
        end
      end

      assign outputs[gi] = out_reg;
    end
  endgenerate

endmodule

// File: tb/tb_mix_matrix_core.sv
// Self-checking bench for mix_matrix_core with a plain-arithmetic matrix model.
module tb_mix_matrix_core;
  localparam int NI = 8;
  localparam int NO = 8;
  localparam int W  = 36;
  localparam int CW = 18;
  localparam int CF = 16;
  localparam int LAT = NI * NO + 3;

  logic clk = 1'b0;
  logic reset, start, coef_we;
  logic [5:0] coef_addr;
  logic signed [CW-1:0] coef_wdata;
  logic signed [W-1:0] in_drv [NI];
  logic signed [W-1:0] outputs [NO];
  logic busy, done;

  int checks = 0;
  int errors = 0;
  int coef_m [NI*NO];
  logic signed [W-1:0] prev_m [NO];

  always #5 clk = ~clk;

  mix_matrix_core #(.NUM_IN(NI), .NUM_OUT(NO), .WIDTH(W), .COEF_WIDTH(CW), .COEF_FRAC(CF)) dut (
    .clk(clk), .reset(reset), .start(start), .inputs(in_drv), .outputs(outputs),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata),
    .busy(busy), .done(done)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic signed [W-1:0] model_row(input int j, input logic signed [W-1:0] x [NI]);
    longint acc, sh, smax, smin;
    acc = 0;
    for (int i = 0; i < NI; i++) acc += longint'(x[i]) * longint'(coef_m[j*NI+i]);
    sh = acc >>> CF;
    smax = (longint'(1) <<< (W-1)) - 1;
    smin = -(longint'(1) <<< (W-1));
`ifdef MIX_SATURATE_EN
    if (sh > smax) sh = smax;
    else if (sh < smin) sh = smin;
`endif
    return W'(sh);
  endfunction

  function automatic logic signed [W-1:0] rand_sample();
    return W'({$urandom, $urandom});
  endfunction

  function automatic int rand_coef();
    logic signed [CW-1:0] r;
    r = CW'($urandom);
    return int'(r);
  endfunction

  task automatic write_coef(input int addr, input int val);
    coef_we = 1'b1;
    coef_addr = 6'(addr);
    coef_wdata = CW'(val);
    @(negedge clk);
    coef_we = 1'b0;
    coef_m[addr] = val;
  endtask

  task automatic set_identity();
    for (int a = 0; a < NI*NO; a++) write_coef(a, ((a / NI) == (a % NI)) ? 'h10000 : 0);
  endtask

  // One sample: start, watch for done, compare against the model.
  task automatic run_sample(input string tag, input int second_start, input int rbw_cycle,
                            input int rbw_val, input bit scramble);
    logic signed [W-1:0] snap [NI];
    logic signed [W-1:0] exp_v [NO];
    int done_at, extra;
    bit held, busy_ok;
    snap = in_drv;
    for (int j = 0; j < NO; j++) exp_v[j] = model_row(j, snap);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    done_at = -1;
    held = 1'b1;
    busy_ok = 1'b1;
    for (int cyc = 0; cyc < 200; cyc++) begin
      if (done === 1'b1) begin
        done_at = cyc;
        break;
      end
      if (busy !== 1'b1) busy_ok = 1'b0;
      for (int j = 0; j < NO; j++) if (outputs[j] !== prev_m[j]) held = 1'b0;
      start = (cyc == second_start);
      coef_we = (cyc == rbw_cycle);
      if (cyc == rbw_cycle) begin
        coef_addr = 6'(rbw_cycle);
        coef_wdata = CW'(rbw_val);
      end
      if (scramble && cyc == 3) for (int i = 0; i < NI; i++) in_drv[i] = rand_sample();
      @(negedge clk);
    end
    start = 1'b0;
    coef_we = 1'b0;
    check({tag, " latency"}, done_at, LAT);
    check({tag, " busy_during_run"}, busy_ok, 1'b1);
    check({tag, " outputs_held"}, held, 1'b1);
    for (int j = 0; j < NO; j++) check($sformatf("%s out%0d", tag, j), outputs[j], exp_v[j]);
    $display("sample %s: done after %0d cycles, out0=0x%0h", tag, done_at, outputs[0]);
    prev_m = exp_v;
    if (rbw_cycle >= 0) coef_m[rbw_cycle] = rbw_val;
    @(negedge clk);
    check({tag, " done_pulse_width"}, done, 1'b0);
    check({tag, " busy_after_done"}, busy, 1'b0);
    if (second_start >= 0) begin
      extra = 0;
      repeat (80) begin
        @(negedge clk);
        if (done === 1'b1) extra++;
      end
      check({tag, " no_second_done"}, extra, 0);
    end
  endtask

  initial begin
    logic signed [W-1:0] kc;
    int nv, extra;
    reset = 1'b1;
    start = 1'b0;
    coef_we = 1'b0;
    coef_addr = '0;
    coef_wdata = '0;
    for (int i = 0; i < NI; i++) in_drv[i] = '0;
    for (int j = 0; j < NO; j++) prev_m[j] = '0;
    repeat (3) @(negedge clk);
    check("reset busy", busy, 1'b0);
    check("reset done", done, 1'b0);
    for (int j = 0; j < NO; j++) check($sformatf("reset out%0d", j), outputs[j], 0);
    reset = 1'b0;

    // identity matrix
    set_identity();
    for (int i = 0; i < NI; i++) in_drv[i] = W'((i + 1) << 10);
    run_sample("identity", -1, -1, 0, 1'b0);
    kc = W'(4 << 10);
    check("identity const out3", outputs[3], kc);

    // row sum with half gain
    for (int i = 0; i < NI; i++) write_coef(i, 'h8000);
    run_sample("rowsum", -1, -1, 0, 1'b0);
    kc = W'('h4800);
    check("rowsum const out0", outputs[0], kc);

    // overflow of row 0
    for (int i = 0; i < NI; i++) in_drv[i] = 36'h7FFFFFFFF;
    for (int i = 0; i < NI; i++) write_coef(i, 'h10000);
    run_sample("overflow", -1, -1, 0, 1'b0);
`ifdef MIX_SATURATE_EN
    kc = 36'h7FFFFFFFF;
`else
    kc = 36'hFFFFFFFF8;
`endif
    check("overflow const out0", outputs[0], kc);

    // floor rounding of a negative half
    in_drv[0] = -1;
    for (int i = 1; i < NI; i++) in_drv[i] = rand_sample();
    write_coef(0, 'h8000);
    for (int i = 1; i < NI; i++) write_coef(i, 0);
    run_sample("floor", -1, -1, 0, 1'b0);
    kc = -1;
    check("floor const out0", outputs[0], kc);

    // start while busy, inputs changing during the run
    for (int i = 0; i < NI; i++) in_drv[i] = rand_sample();
    run_sample("busy_start", 10, -1, 0, 1'b1);

    // random matrix, write to the address being read in the same cycle
    for (int a = 0; a < NI*NO; a++) write_coef(a, rand_coef());
    for (int i = 0; i < NI; i++) in_drv[i] = rand_sample();
    nv = rand_coef();
    if (nv == coef_m[10]) nv = nv ^ 1;
    run_sample("rbw", -1, 10, nv, 1'b0);
    for (int i = 0; i < NI; i++) in_drv[i] = rand_sample();
    run_sample("rbw_next", -1, -1, 0, 1'b0);

    // further random samples
    for (int t = 0; t < 3; t++) begin
      for (int a = 0; a < NI*NO; a++) write_coef(a, rand_coef());
      for (int i = 0; i < NI; i++) in_drv[i] = rand_sample();
      run_sample($sformatf("random%0d", t), -1, -1, 0, 1'b1);
    end

    // reset in the middle of RUN
    set_identity();
    for (int i = 0; i < NI; i++) in_drv[i] = W'((i + 1) << 10);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (29) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midreset busy", busy, 1'b0);
    check("midreset done", done, 1'b0);
    for (int j = 0; j < NO; j++) check($sformatf("midreset out%0d", j), outputs[j], 0);
    extra = 0;
    repeat (80) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) extra++;
    end
    check("midreset stays idle", extra, 0);
    $display("sample midreset: aborted at RUN cycle 30");
    for (int j = 0; j < NO; j++) prev_m[j] = '0;
    run_sample("after_reset", -1, -1, 0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
